// File: rtl/risc_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and fetch geometry.
// Imported by the fetch unit and available to any later pipeline stages.
package risc_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;
    localparam int INSTR_BYTES    = 4;
    localparam int ALIGN_BITS     = $clog2(INSTR_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request at a time, holds the
// returned word for decode and pulses pc_adv on acceptance; branches squash fetches.
module fetch_unit
    import risc_pkg::*;
#(
    parameter int ADDR_W = risc_pkg::DEFAULT_ADDR_W,
    parameter int DATA_W = risc_pkg::DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              Branch,
    output logic              pc_adv,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              fetch_fault
);

    fetch_state_e      state_q, state_d;
    logic              squash_q, squash_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              misaligned;

    assign misaligned = (pc[ALIGN_BITS-1:0] != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            squash_q <= 1'b0;
            addr_q   <= '0;
            instr_q  <= '0;
            ipc_q    <= '0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        unique case (state_q)
            IDLE: begin
                // During a Branch pulse pc is not yet the target, so wait a cycle to latch it.
                if (!Branch) begin
                    addr_d  = pc;
                    state_d = misaligned ? FAULT : REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    squash_d = 1'b0;
                    if (Branch) begin
                        state_d = IDLE;
                    end else if (squash_q) begin
                        addr_d  = pc;
                        state_d = misaligned ? FAULT : REQ;
                    end else begin
                        instr_d = mem_rdata;
                        ipc_d   = addr_q;
                        state_d = HOLD;
                    end
                end else if (Branch) begin
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                if (Branch || instr_ready) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                if (Branch) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req     = (state_q == REQ);
    assign mem_addr    = addr_q;
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign fetch_fault = (state_q == FAULT);
    assign pc_adv      = (state_q == HOLD) && instr_ready && !Branch;

endmodule
